// File: rtl/avalonmm_key_master.sv
// -----------------------------------------------------------------------------
// avalonmm_key_master
//
// Avalon-MM master that services a key PIO slave. After reset it programs the
// PIO interrupt mask. On each interrupt it reads the edge-capture register,
// clears the captured bits, samples the key levels, and presents the result as
// a valid/ready event. A new interrupt mask can be requested at any time and
// is written the next time the FSM passes through IDLE.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   irq          interrupt from the key PIO
//   address      Avalon-MM word address (0 data, 2 irq mask, 3 edge capture)
//   chipselect   Avalon-MM chip select
//   write_n      Avalon-MM write strobe, active-low
//   writedata    Avalon-MM write data
//   readdata     Avalon-MM read data, fixed read latency of one cycle
//   cfg_mask     new interrupt mask value
//   cfg_mask_wr  one-cycle request to write cfg_mask to the PIO
//   evt_valid    key event available
//   evt_ready    consumer accepts the event
//   evt_edges    captured edge bits of the event
//   evt_level    key levels sampled after the clear
//   evt_count    number of accepted events, wraps modulo 2^CNT_W
//   busy         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module avalonmm_key_master #(
  parameter logic [3:0] MASK_INIT = 4'hF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic [3:0]       cfg_mask,
  input  logic             cfg_mask_wr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_edges,
  output logic [3:0]       evt_level,
  output logic [CNT_W-1:0] evt_count,
  output logic             busy
);

  typedef enum logic [3:0] {
    BOOT,
    INIT_MASK,
    IDLE,
    MASK_WR,
    RD_EC,
    CAP_EC,
    CLR_EC,
    RD_LV,
    CAP_LV,
    EVT
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  state_t           state_q, state_d;
  logic [3:0]       edge_q;
  logic [3:0]       level_q;
  logic [3:0]       mask_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;

  // Only the low nibble of the PIO registers carries key information.
  logic unused_readdata;
  assign unused_readdata = ^readdata[31:4];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = ADDR_DATA;
    writedata  = 32'h0;

    case (state_q)
      BOOT: begin
        state_d = INIT_MASK;
      end

      INIT_MASK: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_MASK;
        writedata  = {28'h0, MASK_INIT};
        state_d    = IDLE;
      end

      IDLE: begin
        // A pending mask write takes priority over servicing the interrupt.
        if (pend_q) begin
          state_d = MASK_WR;
        end else if (irq) begin
          state_d = RD_EC;
        end
      end

      MASK_WR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_MASK;
        writedata  = {28'h0, mask_q};
        state_d    = IDLE;
      end

      RD_EC: begin
        chipselect = 1'b1;
        address    = ADDR_EDGE;
        state_d    = CAP_EC;
      end

      CAP_EC: begin
        state_d = CLR_EC;
      end

      CLR_EC: begin
        // Writing the captured bits back clears exactly those edges.
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_EDGE;
        writedata  = {28'h0, edge_q};
        state_d    = RD_LV;
      end

      RD_LV: begin
        chipselect = 1'b1;
        address    = ADDR_DATA;
        state_d    = CAP_LV;
      end

      CAP_LV: begin
        // No captured edge means the interrupt was spurious: no event.
        state_d = (edge_q != 4'h0) ? EVT : IDLE;
      end

      EVT: begin
        if (evt_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured edge / level registers and event counter
  // ---------------------------------------------------------------------------
  // NOTE: these are control/status registers, not a memory array, so they all
  // take the reset; the outputs must read zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q  <= 4'h0;
      level_q <= 4'h0;
      cnt_q   <= '0;
    end else begin
      // Read data arrives one cycle after the read state.
      if (state_q == CAP_EC) begin
        edge_q <= readdata[3:0];
      end
      if (state_q == CAP_LV) begin
        level_q <= readdata[3:0];
      end
      if (state_q == EVT && evt_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending mask request
  // ---------------------------------------------------------------------------
  // A new request always wins over the clear on leaving MASK_WR, so a request
  // that lands on the exit cycle is serviced by a further mask write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= 4'h0;
      pend_q <= 1'b0;
    end else begin
      if (cfg_mask_wr) begin
        mask_q <= cfg_mask;
        pend_q <= 1'b1;
      end else if (state_q == MASK_WR) begin
        pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event and status outputs
  // ---------------------------------------------------------------------------
  assign evt_valid = (state_q == EVT);
  assign evt_edges = edge_q;
  assign evt_level = level_q;
  assign evt_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_avalonmm_key_master.sv
// -----------------------------------------------------------------------------
// tb_avalonmm_key_master
//
// Bench for avalonmm_key_master. A small key PIO model answers bus cycles.
// Expected bus cycles and expected events are queued when stimulus is applied
// and compared in order by monitors as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_avalonmm_key_master;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             irq;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [3:0]       cfg_mask;
  logic             cfg_mask_wr;
  logic             evt_valid;
  logic             evt_ready;
  logic [3:0]       evt_edges;
  logic [3:0]       evt_level;
  logic [CNT_W-1:0] evt_count;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Bus op packing: {write_n, address, writedata}; read ops carry zero data.
  logic [34:0] exp_bus[$];
  logic [7:0]  exp_evt[$];

  // PIO model state
  logic [3:0] pio_edge;
  logic [3:0] pio_level;
  logic [3:0] pio_mask;
  logic [3:0] edge_inject;

  avalonmm_key_master #(
    .MASK_INIT (4'hF),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .cfg_mask    (cfg_mask),
    .cfg_mask_wr (cfg_mask_wr),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_edges   (evt_edges),
    .evt_level   (evt_level),
    .evt_count   (evt_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] bus_op(input logic wr, input logic [1:0] a, input logic [31:0] d);
    return {~wr, a, (wr ? d : 32'h0)};
  endfunction

  // Key PIO model: registered read data (latency 1), edge capture cleared by
  // writing ones to address 3. Upper read bits are junk the DUT must ignore.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pio_edge <= 4'h0;
      pio_mask <= 4'h0;
      readdata <= 32'h0;
    end else begin
      pio_edge <= (pio_edge | edge_inject) &
                  ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0);
      if (chipselect && !write_n && address == 2'd2) pio_mask <= writedata[3:0];
      if (chipselect && write_n) begin
        case (address)
          2'd0:    readdata <= {28'hA5A5A5A, pio_level};
          2'd2:    readdata <= {28'hA5A5A5A, pio_mask};
          2'd3:    readdata <= {28'hA5A5A5A, pio_edge};
          default: readdata <= 32'hA5A5A5A0;
        endcase
      end
    end
  end

  // Bus monitor: every bus cycle must match the next expected op.
  always @(negedge clk) begin
    logic [34:0] got, exp;
    if (!reset && chipselect) begin
      got = {write_n, address, (write_n ? 32'h0 : writedata)};
      exp = (exp_bus.size() != 0) ? exp_bus.pop_front() : '1;
      chk("bus", {29'h0, got}, {29'h0, exp});
    end
  end

  // Event monitor: every accepted event must match the next expected one.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!reset && evt_valid && evt_ready) begin
      exp = (exp_evt.size() != 0) ? exp_evt.pop_front() : 8'hFF;
      chk("evt", {56'h0, evt_edges, evt_level}, {56'h0, exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [3:0] e);
    step();
    edge_inject = e;
    step();
    edge_inject = 4'h0;
  endtask

  // Wait (bounded) until the DUT drives the given bus cycle.
  task automatic wait_bus(input string tag, input logic wn, input logic [1:0] a);
    logic found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (chipselect && write_n == wn && address == a) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {63'h0, found}, 64'h1);
  endtask

  // Raise irq in IDLE for one cycle and return cycles until evt_valid.
  task automatic irq_pulse_latency(output int lat);
    lat = 0;
    irq = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) irq = 1'b0;
      if (evt_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic seen;

    reset = 1'b1; irq = 1'b0; cfg_mask = 4'h0; cfg_mask_wr = 1'b0;
    evt_ready = 1'b0; pio_level = 4'hD; edge_inject = 4'h0;

    // ---------------- reset values and boot sequence ----------------
    repeat (3) step();
    chk("rst_cs",    {63'h0, chipselect}, 64'h0);
    chk("rst_wn",    {63'h0, write_n},    64'h1);
    chk("rst_addr",  {62'h0, address},    64'h0);
    chk("rst_wd",    {32'h0, writedata},  64'h0);
    chk("rst_valid", {63'h0, evt_valid},  64'h0);
    chk("rst_edges", {60'h0, evt_edges},  64'h0);
    chk("rst_level", {60'h0, evt_level},  64'h0);
    chk("rst_count", {48'h0, evt_count},  64'h0);
    chk("rst_busy",  {63'h0, busy},       64'h1);

    exp_bus.push_back(bus_op(1'b1, 2'd2, 32'h0000000F));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_cs",   {63'h0, chipselect}, 64'h0);
    chk("boot_busy", {63'h0, busy},       64'h1);
    step();
    chk("init_wr", {29'h0, write_n, address, writedata}, {29'h0, 1'b0, 2'd2, 32'h0000000F});
    step();
    chk("idle_busy", {63'h0, busy}, 64'h0);

    // ---------------- full event, consumer ready ----------------
    evt_ready = 1'b1;
    inject(4'b0010);
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd3, 32'h2));
    exp_bus.push_back(bus_op(1'b0, 2'd0, 32'h0));
    exp_evt.push_back({4'h2, 4'hD});
    irq_pulse_latency(lat);
    chk("lat_ready", lat, 6);
    chk("ev1_edges", {60'h0, evt_edges}, 64'h2);
    chk("ev1_level", {60'h0, evt_level}, 64'hD);
    step();
    chk("ev1_count", {48'h0, evt_count}, 64'h1);
    chk("ev1_done",  {62'h0, evt_valid, busy}, 64'h0);

    // ---------------- event held under backpressure ----------------
    evt_ready = 1'b0;
    inject(4'b0010);
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd3, 32'h2));
    exp_bus.push_back(bus_op(1'b0, 2'd0, 32'h0));
    exp_evt.push_back({4'h2, 4'hD});
    irq_pulse_latency(lat);
    chk("lat_stall", lat, 6);
    for (int i = 0; i < 5; i++) begin
      chk("hold", {44'h0, evt_valid, evt_edges, evt_level, evt_count[6:0]},
                  {44'h0, 1'b1, 4'h2, 4'hD, 7'd1});
      step();
    end
    evt_ready = 1'b1;
    step();
    chk("ev2_count", {48'h0, evt_count}, 64'h2);
    chk("ev2_valid", {63'h0, evt_valid}, 64'h0);

    // ---------------- spurious interrupt ----------------
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b0, 2'd0, 32'h0));
    irq_pulse_latency(lat);
    seen = (lat != 0);
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | evt_valid;
    end
    chk("spur_noevt", {63'h0, seen},      64'h0);
    chk("spur_count", {48'h0, evt_count}, 64'h2);
    chk("spur_busy",  {63'h0, busy},      64'h0);
    chk("spur_bus",   exp_bus.size(),     0);

    // ---------------- mask write requests during service ----------------
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b0, 2'd0, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd2, 32'h3));
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b1, 2'd3, 32'h0));
    exp_bus.push_back(bus_op(1'b0, 2'd0, 32'h0));
    irq = 1'b1;
    wait_bus("mw_rdec", 1'b1, 2'd3);
    cfg_mask = 4'h5; cfg_mask_wr = 1'b1;
    step();
    cfg_mask_wr = 1'b0;
    wait_bus("mw_rdlv", 1'b1, 2'd0);
    step();
    cfg_mask = 4'h3; cfg_mask_wr = 1'b1;
    step();
    cfg_mask_wr = 1'b0;
    wait_bus("mw_rdec2", 1'b1, 2'd3);
    irq = 1'b0;
    repeat (8) step();
    chk("mw_bus",   exp_bus.size(),                                          0);
    chk("mw_count", {48'h0, evt_count},                                      64'h2);
    chk("mw_pio",   {60'h0, pio_mask},                                       64'h3);

    // ---------------- reset in the middle of CLR_EC ----------------
    inject(4'b0100);
    exp_bus.push_back(bus_op(1'b0, 2'd3, 32'h0));
    irq = 1'b1;
    wait_bus("rs_rdec", 1'b1, 2'd3);
    irq = 1'b0;
    step();
    step();
    chk("rs_in_clr", {29'h0, write_n, address, writedata}, {29'h0, 1'b0, 2'd3, 32'h4});
    reset = 1'b1;
    #1;
    chk("rs_bus",   {29'h0, chipselect, write_n, address, writedata[28:0]}, {29'h0, 1'b0, 1'b1, 2'd0, 29'h0});
    chk("rs_evt",   {40'h0, evt_valid, evt_edges, evt_level, busy, evt_count[13:0]},
                    {40'h0, 1'b0, 4'h0, 4'h0, 1'b1, 14'h0});
    repeat (2) step();
    exp_bus.push_back(bus_op(1'b1, 2'd2, 32'h0000000F));
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rs_init", {29'h0, write_n, address, writedata}, {29'h0, 1'b0, 2'd2, 32'h0000000F});
    repeat (3) step();
    chk("rs_idle",  {63'h0, busy},      64'h0);
    chk("rs_count", {48'h0, evt_count}, 64'h0);
    chk("rs_left",  exp_bus.size() + exp_evt.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
